fsqrt_issue_ctrl: RTL

//  Issue/interlock/writeback controller wrapped around the 3-stage float square-root unit.

---
 rtl/fpu_pkg.sv | 21 ++
 rtl/fsqrt_tag_pipe.sv | 26 ++
 rtl/fsqrt_issue_ctrl.sv | 84 ++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: widths, rounding-mode encodings and the pipeline tag type.
package fpu_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RDN = 2'b01;
    localparam logic [1:0] RM_RUP = 2'b10;
    localparam logic [1:0] RM_RTZ = 2'b11;

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] fd;
    } tag_t;

    function automatic logic tag_match(input tag_t t, input logic [REG_AW-1:0] r);
        return t.v & (t.fd == r);
    endfunction

endpackage

// File: rtl/fsqrt_tag_pipe.sv
// Destination-tag shift register mirroring the sqrt unit's E1..E3 stages.
module fsqrt_tag_pipe
    import fpu_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic shift,
    input  tag_t tag_in,
    output tag_t e1,
    output tag_t e2,
    output tag_t e3
);

    always_ff @(posedge clk) begin
        if (rst) begin
            e1 <= '0;
            e2 <= '0;
            e3 <= '0;
        end else if (shift) begin
            e1 <= tag_in;
            e2 <= e1;
            e3 <= e2;
        end
    end

endmodule

// File: rtl/fsqrt_issue_ctrl.sv
// Issue, RAW/structural interlock, W-stage forwarding and writeback around the
// 3-stage float square-root unit.
module fsqrt_issue_ctrl
    import fpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              id_fsqrt,
    input  logic [REG_AW-1:0] id_fd,
    input  logic [1:0]        id_rm,
    input  logic [REG_AW-1:0] id_fs,
    input  logic              id_fs_rd,
    input  logic [REG_AW-1:0] id_ft,
    input  logic              id_ft_rd,
    input  logic              sqrt_busy,
    input  logic              sqrt_stall,
    input  logic [DATA_W-1:0] sqrt_s,
    output logic              sqrt_start,
    output logic              sqrt_en,
    output logic [1:0]        sqrt_rm,
    output logic              id_stall,
    output logic              fwd_fs,
    output logic              fwd_ft,
    output logic [DATA_W-1:0] fwd_data,
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic [1:0]        inflight
);

    tag_t              tag_in, e1, e2, e3;
    logic              raw_fs, raw_ft, raw_hit, struct_hit, issue;
    logic              w_v;
    logic [REG_AW-1:0] w_fd;
    logic [DATA_W-1:0] w_data;

    fsqrt_tag_pipe u_tag_pipe (
        .clk    (clk),
        .rst    (rst),
        .shift  (sqrt_en),
        .tag_in (tag_in),
        .e1     (e1),
        .e2     (e2),
        .e3     (e3)
    );

    always_comb begin
        raw_fs = id_fs_rd & (tag_match(e1, id_fs) | tag_match(e2, id_fs) | tag_match(e3, id_fs));
        raw_ft = id_ft_rd & (tag_match(e1, id_ft) | tag_match(e2, id_ft) | tag_match(e3, id_ft));
        raw_hit    = raw_fs | raw_ft;
        struct_hit = id_fsqrt & sqrt_busy;
        id_stall   = sqrt_stall | raw_hit | struct_hit;
        // Reset forces the unit enabled and suppresses any start strobe.
        issue      = id_fsqrt & ~id_stall & ~rst;
        sqrt_start = issue;
        sqrt_en    = rst | ~sqrt_stall;
        sqrt_rm    = id_rm;
        tag_in.v   = issue;
        tag_in.fd  = id_fd;
        // A younger in-flight writer wins over the W-stage value: stall, don't forward.
        fwd_fs     = id_fs_rd & w_v & (id_fs == w_fd) & ~raw_hit;
        fwd_ft     = id_ft_rd & w_v & (id_ft == w_fd) & ~raw_hit;
        fwd_data   = w_data;
        wb_we      = w_v;
        wb_rd      = w_fd;
        wb_data    = w_data;
        inflight   = {1'b0, e1.v} + {1'b0, e2.v} + {1'b0, e3.v};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_v    <= 1'b0;
            w_fd   <= '0;
            w_data <= '0;
        end else if (sqrt_en && e3.v) begin
            w_v    <= 1'b1;
            w_fd   <= e3.fd;
            w_data <= sqrt_s;
        end else begin
            w_v    <= 1'b0;
        end
    end

endmodule
